ps2_keycode_decoder: RTL and testbench



---
 rtl/ps2_pkg.sv | 61 ++++++
 rtl/ps2_rx_frame.sv | 143 ++++++++++++++
 rtl/ps2_keycode_decoder.sv | 85 ++++++++
 tb/tb_ps2_keycode_decoder.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 keyboard front end: the receive-frame
// state enum, the special Set-2 scan bytes, the HID usage codes produced
// for game control, and the scan-code to HID lookup.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } frame_state_e;

  // Prefix bytes and keyboard status bytes
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;

  // HID usage codes
  localparam logic [7:0] HID_NONE  = 8'h00;
  localparam logic [7:0] HID_A     = 8'h04;
  localparam logic [7:0] HID_D     = 8'h07;
  localparam logic [7:0] HID_S     = 8'h16;
  localparam logic [7:0] HID_W     = 8'h1A;
  localparam logic [7:0] HID_ENTER = 8'h28;
  localparam logic [7:0] HID_SPACE = 8'h2C;
  localparam logic [7:0] HID_RIGHT = 8'h4F;
  localparam logic [7:0] HID_LEFT  = 8'h50;
  localparam logic [7:0] HID_DOWN  = 8'h51;
  localparam logic [7:0] HID_UP    = 8'h52;

  // Extended and plain code spaces are disjoint: an arrow code without
  // its E0 prefix (or a letter code with one) maps to nothing.
  function automatic logic [7:0] scan_to_hid(input logic ext, input logic [7:0] code);
    logic [7:0] hid;
    hid = HID_NONE;
    if (ext) begin
      case (code)
        8'h75:   hid = HID_UP;
        8'h72:   hid = HID_DOWN;
        8'h6B:   hid = HID_LEFT;
        8'h74:   hid = HID_RIGHT;
        default: hid = HID_NONE;
      endcase
    end else begin
      case (code)
        8'h1D:   hid = HID_W;
        8'h1C:   hid = HID_A;
        8'h1B:   hid = HID_S;
        8'h23:   hid = HID_D;
        8'h29:   hid = HID_SPACE;
        8'h5A:   hid = HID_ENTER;
        default: hid = HID_NONE;
      endcase
    end
    return hid;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame
// Receives one 11-bit PS/2 frame (start, 8 data LSB first, odd parity,
// stop) from the raw keyboard lines.
// Ports:
//   Clk, Reset_n  system clock, asynchronous active-low reset
//   ps2_clk       raw PS/2 clock (asynchronous)
//   ps2_data      raw PS/2 data (asynchronous)
//   rx_byte       last received data byte, valid while byte_valid is high
//   byte_valid    one-cycle strobe, cycle after the stop-bit fall of a good frame
//   frame_err     one-cycle pulse on parity, stop-bit or timeout error
//   rx_timeout    one-cycle pulse, coincident with frame_err, for timeouts only
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       rx_timeout
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync, data_sync;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          filt_flip, fall;

  frame_state_e  state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit, valid_d, err_d, timeout_d;

  // Both lines idle high, so the synchronizers and filter reset high.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // The filtered level flips on the FILTER_LEN-th consecutive sample that
  // disagrees with it; any agreeing sample restarts the count.
  assign filt_flip = (clk_sync[1] != clk_filt) && (filt_cnt == FW'(FILTER_LEN - 1));
  assign fall      = filt_flip && clk_filt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_sync[1] == clk_filt) begin
      filt_cnt <= '0;
    end else if (filt_flip) begin
      clk_filt <= clk_sync[1];
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  // A genuine fall in the terminal cycle keeps the frame alive.
  assign tmo_hit = (state_q != IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES - 1)) && !fall;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tmo_q      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      rx_timeout <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tmo_q      <= tmo_d;
      byte_valid <= valid_d;
      frame_err  <= err_d;
      rx_timeout <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    timeout_d = 1'b0;
    tmo_d     = (state_q == IDLE || fall) ? '0 : tmo_q + 1'b1;

    if (tmo_hit) begin
      state_d   = IDLE;
      tmo_d     = '0;
      err_d     = 1'b1;
      timeout_d = 1'b1;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          if (!data_sync[1]) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d   = {data_sync[1], shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          parity_d = data_sync[1];
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (data_sync[1] && ((^shift_q) ^ parity_q)) valid_d = 1'b1;
          else                                         err_d   = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // The shift register is untouched between the stop fall and the strobe.
  assign rx_byte = shift_q;

endmodule

// File: rtl/ps2_keycode_decoder.sv
// ps2_keycode_decoder
// Turns PS/2 Set-2 make/break/extended sequences into a held HID keycode
// on the same 8-bit bus the USB keycode source drives.
// Ports:
//   Clk, Reset_n  system clock, asynchronous active-low reset
//   ps2_clk       raw PS/2 clock (asynchronous)
//   ps2_data      raw PS/2 data (asynchronous)
//   keycode       HID code of the most recent mapped key still held, 0 = none
//   key_event     one-cycle pulse whenever keycode is written
//   frame_err     one-cycle pulse on parity, stop-bit or timeout error
module ps2_keycode_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       key_event,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       byte_valid, rx_timeout;
  logic       ext_q, brk_q;
  logic [7:0] hid;

  ps2_rx_frame #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .rx_timeout (rx_timeout)
  );

  assign hid = scan_to_hid(ext_q, rx_byte);

  // Prefix bytes only arm flags; any other non-status byte consumes them.
  // A break only releases the key currently shown, so releasing an older
  // key while a newer one is held leaves the newer one on the bus.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      keycode   <= HID_NONE;
      key_event <= 1'b0;
    end else begin
      key_event <= 1'b0;
      if (rx_timeout) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (byte_valid) begin
        case (rx_byte)
          PS2_EXT: ext_q <= 1'b1;
          PS2_BRK: brk_q <= 1'b1;
          PS2_ACK, PS2_BAT_OK, PS2_ECHO: begin
          end
          default: begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
            if (hid != HID_NONE) begin
              if (!brk_q) begin
                keycode   <= hid;
                key_event <= 1'b1;
              end else if (hid == keycode) begin
                keycode   <= HID_NONE;
                key_event <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// tb_ps2_keycode_decoder
// Drives PS/2 frames into ps2_keycode_decoder and compares keycode and the
// pulse counts of key_event / frame_err against a behavioural model built
// from lookup tables of the key map.
module tb_ps2_keycode_decoder;

  localparam int FILTER_LEN     = 4;
  localparam int TIMEOUT_CYCLES = 1000;
  localparam int HALF           = 10;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] keycode;
  logic       key_event;
  logic       frame_err;

  ps2_keycode_decoder #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keycode   (keycode),
    .key_event (key_event),
    .frame_err (frame_err)
  );

  always #10 Clk = ~Clk;

  int compared   = 0;
  int mismatched = 0;

  int obs_events = 0;
  int obs_errs   = 0;
  int overlap    = 0;

  // Pulse counters, sampled away from the rising edge
  always @(negedge Clk) begin
    if (key_event) obs_events++;
    if (frame_err) obs_errs++;
    if (key_event && frame_err) overlap++;
  end

  // Reference model state
  logic [7:0] hid_plain [logic [7:0]];
  logic [7:0] hid_ext   [logic [7:0]];
  logic [7:0] m_keycode;
  bit         m_ext, m_brk;
  int         m_events, m_errs;

  function automatic void init_map();
    hid_plain[8'h1D] = 8'h1A;
    hid_plain[8'h1C] = 8'h04;
    hid_plain[8'h1B] = 8'h16;
    hid_plain[8'h23] = 8'h07;
    hid_plain[8'h29] = 8'h2C;
    hid_plain[8'h5A] = 8'h28;
    hid_ext[8'h75]   = 8'h52;
    hid_ext[8'h72]   = 8'h51;
    hid_ext[8'h6B]   = 8'h50;
    hid_ext[8'h74]   = 8'h4F;
  endfunction

  function automatic void model_byte(input logic [7:0] code);
    logic [7:0] hid;
    if (code == 8'hE0) m_ext = 1'b1;
    else if (code == 8'hF0) m_brk = 1'b1;
    else if (!(code inside {8'hFA, 8'hAA, 8'hEE})) begin
      hid = 8'h00;
      if (m_ext && hid_ext.exists(code)) hid = hid_ext[code];
      if (!m_ext && hid_plain.exists(code)) hid = hid_plain[code];
      if (hid != 8'h00) begin
        if (!m_brk) begin
          m_keycode = hid;
          m_events++;
        end else if (hid == m_keycode) begin
          m_keycode = 8'h00;
          m_events++;
        end
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // One PS/2 bit: data changes mid-high, then a low half period.
  // A glitch is a 2-cycle low blip shorter than the filter length.
  task automatic ps2_bit(input bit b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      wait_clks(2);
      ps2_clk = 1'b0;
      wait_clks(2);
      ps2_clk = 1'b1;
      wait_clks(HALF - 4);
    end else begin
      wait_clks(HALF);
    end
    ps2_clk = 1'b0;
    wait_clks(HALF);
    ps2_clk = 1'b1;
  endtask

  // kind: 0 good, 1 bad parity, 2 bad stop bit
  task automatic send_frame(input logic [7:0] code, input int kind, input bit glitch);
    bit par;
    par = ~(^code);
    if (kind == 1) par = ~par;
    ps2_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) ps2_bit(code[i], 1'b0);
    ps2_bit(par, 1'b0);
    ps2_bit((kind == 2) ? 1'b0 : 1'b1, 1'b0);
    ps2_data = 1'b1;
    wait_clks(3 * HALF);
    if (kind == 0) model_byte(code);
    else m_errs++;
  endtask

  task automatic test_reset();
    Reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    m_keycode = 8'h00;
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_events = 0;
    m_errs = 0;
    wait_clks(5);
    compared++;
    if (keycode !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_keycode: got %h expected 00", keycode); end
    compared++;
    if (key_event !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_key_event: got %b expected 0", key_event); end
    compared++;
    if (frame_err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
    Reset_n = 1'b1;
    wait_clks(10);
  endtask

  task automatic test_make_break();
    int ev0;
    ev0 = obs_events;
    send_frame(8'h1D, 0, 1'b0);
    compared++;
    if (keycode !== 8'h1A) begin mismatched++; $display("[TB] FAIL make_w_keycode: got %h expected 1a", keycode); end
    compared++;
    if (obs_events - ev0 !== 1) begin mismatched++; $display("[TB] FAIL make_w_event: got %0d pulses expected 1", obs_events - ev0); end
    ev0 = obs_events;
    send_frame(8'hF0, 0, 1'b0);
    send_frame(8'h1D, 0, 1'b0);
    compared++;
    if (keycode !== 8'h00) begin mismatched++; $display("[TB] FAIL break_w_keycode: got %h expected 00", keycode); end
    compared++;
    if (obs_events - ev0 !== 1) begin mismatched++; $display("[TB] FAIL break_w_event: got %0d pulses expected 1", obs_events - ev0); end
  endtask

  task automatic test_extended();
    int ev0;
    send_frame(8'hE0, 0, 1'b0);
    send_frame(8'h75, 0, 1'b0);
    compared++;
    if (keycode !== 8'h52) begin mismatched++; $display("[TB] FAIL ext_up_make: got %h expected 52", keycode); end
    send_frame(8'hE0, 0, 1'b0);
    send_frame(8'hF0, 0, 1'b0);
    send_frame(8'h75, 0, 1'b0);
    compared++;
    if (keycode !== 8'h00) begin mismatched++; $display("[TB] FAIL ext_up_break: got %h expected 00", keycode); end
    ev0 = obs_events;
    send_frame(8'h75, 0, 1'b0);
    compared++;
    if (keycode !== 8'h00 || obs_events != ev0) begin
      mismatched++;
      $display("[TB] FAIL plain_75_ignored: got keycode %h, %0d pulses expected 00, 0", keycode, obs_events - ev0);
    end
  endtask

  task automatic test_overlap();
    int ev0;
    send_frame(8'h1D, 0, 1'b0);
    send_frame(8'h23, 0, 1'b0);
    compared++;
    if (keycode !== 8'h07) begin mismatched++; $display("[TB] FAIL hold_w_press_d: got %h expected 07", keycode); end
    ev0 = obs_events;
    send_frame(8'hF0, 0, 1'b0);
    send_frame(8'h1D, 0, 1'b0);
    compared++;
    if (keycode !== 8'h07) begin mismatched++; $display("[TB] FAIL break_old_key_keycode: got %h expected 07", keycode); end
    compared++;
    if (obs_events != ev0) begin mismatched++; $display("[TB] FAIL break_old_key_event: got %0d pulses expected 0", obs_events - ev0); end
  endtask

  task automatic test_frame_errors();
    int er0;
    er0 = obs_errs;
    send_frame(8'h1C, 1, 1'b0);
    compared++;
    if (obs_errs - er0 !== 1) begin mismatched++; $display("[TB] FAIL parity_err_pulse: got %0d pulses expected 1", obs_errs - er0); end
    compared++;
    if (keycode !== 8'h07) begin mismatched++; $display("[TB] FAIL parity_err_keycode: got %h expected 07", keycode); end
    er0 = obs_errs;
    send_frame(8'h29, 2, 1'b0);
    compared++;
    if (obs_errs - er0 !== 1 || keycode !== 8'h07) begin
      mismatched++;
      $display("[TB] FAIL stop_err: got %0d pulses keycode %h expected 1, 07", obs_errs - er0, keycode);
    end
    send_frame(8'h1C, 0, 1'b0);
    compared++;
    if (keycode !== 8'h04) begin mismatched++; $display("[TB] FAIL good_after_err: got %h expected 04", keycode); end
  endtask

  task automatic test_timeout();
    int er0;
    send_frame(8'hE0, 0, 1'b0);
    er0 = obs_errs;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(i[0], 1'b0);
    ps2_data = 1'b1;
    wait_clks(TIMEOUT_CYCLES + 100);
    m_errs++;
    m_ext = 1'b0;
    m_brk = 1'b0;
    compared++;
    if (obs_errs - er0 !== 1) begin mismatched++; $display("[TB] FAIL timeout_pulse: got %0d pulses expected 1", obs_errs - er0); end
    send_frame(8'h75, 0, 1'b0);
    compared++;
    if (keycode !== 8'h04) begin mismatched++; $display("[TB] FAIL timeout_clears_ext: got %h expected 04", keycode); end
    send_frame(8'h1B, 0, 1'b0);
    compared++;
    if (keycode !== 8'h16) begin mismatched++; $display("[TB] FAIL after_timeout: got %h expected 16", keycode); end
  endtask

  task automatic test_reset_mid_frame();
    int er0, ev0;
    logic [7:0] cut;
    cut = 8'hF0;
    send_frame(8'h1D, 0, 1'b0);
    compared++;
    if (keycode !== 8'h1A) begin mismatched++; $display("[TB] FAIL pre_reset_keycode: got %h expected 1a", keycode); end
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(cut[i], 1'b0);
    Reset_n = 1'b0;
    #1;
    compared++;
    if (keycode !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_async_keycode: got %h expected 00", keycode); end
    wait_clks(3);
    Reset_n = 1'b1;
    m_keycode = 8'h00;
    m_ext = 1'b0;
    m_brk = 1'b0;
    er0 = obs_errs;
    for (int i = 4; i < 8; i++) ps2_bit(cut[i], 1'b0);
    ps2_bit(~(^cut), 1'b0);
    ps2_bit(1'b1, 1'b0);
    wait_clks(3 * HALF);
    ev0 = obs_events;
    send_frame(8'h29, 0, 1'b0);
    compared++;
    if (keycode !== 8'h2C) begin mismatched++; $display("[TB] FAIL after_reset_space: got %h expected 2c", keycode); end
    compared++;
    if (obs_events - ev0 !== 1 || obs_errs != er0) begin
      mismatched++;
      $display("[TB] FAIL after_reset_pulses: got %0d events %0d errs expected 1, 0", obs_events - ev0, obs_errs - er0);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [16];
    logic [7:0] code;
    int kind;
    pool = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'h5A, 8'h75, 8'h72,
             8'h6B, 8'h74, 8'hE0, 8'hF0, 8'hFA, 8'hAA, 8'hEE, 8'h00};
    for (int n = 0; n < 60; n++) begin
      code = pool[$urandom_range(0, 15)];
      if (code == 8'h00) code = 8'($urandom_range(0, 255));
      kind = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
      send_frame(code, kind, $urandom_range(0, 3) == 0);
      compared++;
      if (keycode !== m_keycode) begin
        mismatched++;
        $display("[TB] FAIL rand_keycode[%0d] byte %h: got %h expected %h", n, code, keycode, m_keycode);
      end
      compared++;
      if (obs_events != m_events) begin
        mismatched++;
        $display("[TB] FAIL rand_events[%0d] byte %h: got %0d expected %0d", n, code, obs_events, m_events);
      end
      compared++;
      if (obs_errs != m_errs) begin
        mismatched++;
        $display("[TB] FAIL rand_errs[%0d] byte %h: got %0d expected %0d", n, code, obs_errs, m_errs);
      end
    end
  endtask

  initial begin
    init_map();
    test_reset();
    test_make_break();
    test_extended();
    test_overlap();
    test_frame_errors();
    test_timeout();
    test_reset_mid_frame();
    test_random();
    compared++;
    if (overlap != 0) begin
      mismatched++;
      $display("[TB] FAIL event_err_overlap: got %0d shared cycles expected 0", overlap);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
